// File: rtl/game_pkg.sv
// Shared game/display constants and types.
// Matrix geometry, cell size, visible-area origin and index/position widths.
package game_pkg;

  localparam int MAT_W           = 80;
  localparam int MAT_H           = 50;
  localparam int CELL_SHIFT      = 4;
  localparam int MOVE_TO_CENTER  = 7;
  localparam int H_VISIBLE_START = 336;
  localparam int V_VISIBLE_START = 27;

  localparam int IDX_X_W = 7;
  localparam int IDX_Y_W = 6;
  localparam int POS_X_W = 11;
  localparam int POS_Y_W = 10;

  typedef logic [IDX_X_W-1:0] idx_x_t;
  typedef logic [IDX_Y_W-1:0] idx_y_t;
  typedef logic [POS_X_W-1:0] pos_x_t;
  typedef logic [POS_Y_W-1:0] pos_y_t;

  typedef struct packed {
    logic   oob;
    pos_x_t pos_x;
    pos_y_t pos_y;
  } cell_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus masked priority search.
// Ports: clk, rst, req, advance -> grant (one-hot), grant_id, any_req.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [ID_W-1:0] last_grant;
  int              pos;

  // Search starts one past the last winner and wraps.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    pos      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_grant) + k) % NUM_REQ;
      if (!any_req && req[pos]) begin
        any_req     = 1'b1;
        grant[pos]  = 1'b1;
        grant_id    = ID_W'(pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (advance) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/cell_pos_arbiter.sv
// Shares one matrix-index to display-centre converter among requesters.
// Ports: req_valid/ready/idx per requester, flush, rsp_* output, busy.
module cell_pos_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int MAT_W           = game_pkg::MAT_W,
  parameter int MAT_H           = game_pkg::MAT_H,
  parameter int CELL_SHIFT      = game_pkg::CELL_SHIFT,
  parameter int MOVE_TO_CENTER  = game_pkg::MOVE_TO_CENTER,
  parameter int H_VISIBLE_START = game_pkg::H_VISIBLE_START,
  parameter int V_VISIBLE_START = game_pkg::V_VISIBLE_START
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*7-1:0]   req_idx_x,
  input  logic [NUM_REQ*6-1:0]   req_idx_y,
  input  logic                   flush,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [10:0]            rsp_pos_x,
  output logic [9:0]             rsp_pos_y,
  output logic                   rsp_oob,
  output logic                   busy
);

  import game_pkg::*;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]         state;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any_req;
  logic               can_load;
  logic               advance;
  idx_x_t             sel_x;
  idx_y_t             sel_y;
  cell_rsp_t          sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  assign can_load  = ~flush & ((state == EMPTY) | rsp_ready);
  assign advance   = can_load & any_req;
  assign req_ready = grant & {NUM_REQ{can_load}};

  always_comb begin
    sel_x     = req_idx_x[int'(grant_id)*IDX_X_W +: IDX_X_W];
    sel_y     = req_idx_y[int'(grant_id)*IDX_Y_W +: IDX_Y_W];
    sel.oob   = (int'(sel_x) >= MAT_W) | (int'(sel_y) >= MAT_H);
    sel.pos_x = '0;
    sel.pos_y = '0;
    if (!sel.oob) begin
      sel.pos_x = (POS_X_W'(sel_x) << CELL_SHIFT)
                + POS_X_W'(MOVE_TO_CENTER + H_VISIBLE_START);
      sel.pos_y = (POS_Y_W'(sel_y) << CELL_SHIFT)
                + POS_Y_W'(MOVE_TO_CENTER + V_VISIBLE_START);
    end
  end

  // Payload is held when nothing loads, so a dropped or
  // consumed response leaves the last values visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      rsp_id    <= '0;
      rsp_pos_x <= '0;
      rsp_pos_y <= '0;
      rsp_oob   <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (can_load) begin
      if (any_req) begin
        state     <= FULL;
        rsp_id    <= grant_id;
        rsp_pos_x <= sel.pos_x;
        rsp_pos_y <= sel.pos_y;
        rsp_oob   <= sel.oob;
      end else begin
        state <= EMPTY;
      end
    end
  end

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid & ~rsp_ready;

endmodule

// File: tb/tb_cell_pos_arbiter.sv
// Self-checking bench for cell_pos_arbiter: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cell_pos_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*7-1:0] req_idx_x;
  logic [N*6-1:0] req_idx_y;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [10:0]  rsp_pos_x;
  logic [9:0]   rsp_pos_y;
  logic         rsp_oob;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit model_ok = 0;
  bit m_valid;
  int m_id, m_px, m_py, m_last;
  bit m_oob;

  always #5 clk = ~clk;

  cell_pos_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx_x (req_idx_x),
    .req_idx_y (req_idx_y),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_pos_x (rsp_pos_x),
    .rsp_pos_y (rsp_pos_y),
    .rsp_oob   (rsp_oob),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idx(input int i, input int x, input int y);
    req_idx_x[i*7 +: 7] = 7'(x);
    req_idx_y[i*6 +: 6] = 6'(y);
  endtask

  function automatic int model_winner();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_last + k) % N;
      if (req_valid[p]) return p;
    end
    return -1;
  endfunction

  // Compare at the falling edge, then advance the model to the next edge.
  task automatic cycle();
    int w;
    bit cl;
    int x, y;
    @(negedge clk);
    w  = model_winner();
    cl = !flush && (!m_valid || rsp_ready);
    if (model_ok) begin
      chk("req_ready", int'(req_ready), (cl && w >= 0) ? (1 << w) : 0);
      chk("rsp_valid", int'(rsp_valid), int'(m_valid));
      chk("rsp_id",    int'(rsp_id),    m_id);
      chk("rsp_pos_x", int'(rsp_pos_x), m_px);
      chk("rsp_pos_y", int'(rsp_pos_y), m_py);
      chk("rsp_oob",   int'(rsp_oob),   int'(m_oob));
      chk("busy",      int'(busy),      int'(m_valid && !rsp_ready));
    end
    if (rst) begin
      model_ok = 1;
      m_valid = 0; m_id = 0; m_px = 0; m_py = 0; m_oob = 0;
      m_last = N - 1;
    end else if (flush) begin
      m_valid = 0;
    end else if (cl) begin
      if (w >= 0) begin
        x = int'(req_idx_x[w*7 +: 7]);
        y = int'(req_idx_y[w*6 +: 6]);
        m_valid = 1;
        m_id    = w;
        m_last  = w;
        m_oob   = (x >= 80) || (y >= 50);
        m_px    = m_oob ? 0 : x * 16 + 7 + 336;
        m_py    = m_oob ? 0 : y * 16 + 7 + 27;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; rsp_ready = 1;
    req_valid = '0; req_idx_x = '0; req_idx_y = '0;
    cycle();
    cycle();
    rst = 0;
    chk("reset_valid", int'(rsp_valid), 0);
    chk("reset_pos_x", int'(rsp_pos_x), 0);
    chk("reset_id",    int'(rsp_id), 0);

    // single request at cell (0,0)
    req_valid = 4'b0001;
    set_idx(0, 0, 0);
    #1 chk("t1_ready", int'(req_ready), 1);
    cycle();
    req_valid = '0;
    chk("t1_valid", int'(rsp_valid), 1);
    chk("t1_id",    int'(rsp_id), 0);
    chk("t1_px",    int'(rsp_pos_x), 343);
    chk("t1_py",    int'(rsp_pos_y), 34);
    chk("t1_oob",   int'(rsp_oob), 0);
    cycle();

    // all requesters valid: rotation 1,2,3,0,...
    req_valid = 4'hF;
    set_idx(0, 1, 2); set_idx(1, 4, 4); set_idx(2, 20, 30);
    set_idx(3, 79, 49);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t2_id", int'(rsp_id), (k + 1) % 4);
      if ((k + 1) % 4 == 3) begin
        chk("t2_px", int'(rsp_pos_x), 1607);
        chk("t2_py", int'(rsp_pos_y), 818);
      end
    end
    req_valid = '0;
    cycle();

    // back-pressure hold
    req_valid = 4'b0010;
    set_idx(1, 10, 5);
    cycle();
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_busy",  int'(busy), 1);
      chk("t3_ready", int'(req_ready), 0);
      chk("t3_px",    int'(rsp_pos_x), 503);
      chk("t3_py",    int'(rsp_pos_y), 114);
      chk("t3_id",    int'(rsp_id), 1);
      cycle();
    end
    rsp_ready = 1;
    #1 chk("t3_release", int'(req_ready), 2);
    cycle();
    req_valid = '0;
    cycle();

    // out-of-range indices
    req_valid = 4'b0100;
    set_idx(2, 80, 3);
    cycle();
    chk("t4_oob_x", int'(rsp_oob), 1);
    chk("t4_px",    int'(rsp_pos_x), 0);
    chk("t4_py",    int'(rsp_pos_y), 0);
    set_idx(2, 3, 50);
    cycle();
    chk("t4_oob_y", int'(rsp_oob), 1);
    req_valid = '0;
    cycle();

    // flush while full
    req_valid = 4'b0001;
    set_idx(0, 1, 1);
    rsp_ready = 0;
    cycle();
    flush = 1;
    #1 chk("t5_flush_ready", int'(req_ready), 0);
    cycle();
    flush = 0;
    chk("t5_valid_after", int'(rsp_valid), 0);
    #1 chk("t5_regrant", int'(req_ready), 1);
    cycle();
    chk("t5_valid_load", int'(rsp_valid), 1);

    // reset while full with requests pending
    req_valid = 4'hF;
    rsp_ready = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_valid", int'(rsp_valid), 0);
    chk("t6_px",    int'(rsp_pos_x), 0);
    chk("t6_py",    int'(rsp_pos_y), 0);
    chk("t6_oob",   int'(rsp_oob), 0);
    rsp_ready = 1;
    #1 chk("t6_prio", int'(req_ready), 1);
    cycle();
    req_valid = '0;
    cycle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        int x, y;
        x = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 127)
                                         : $urandom_range(0, 79);
        y = ($urandom_range(0, 9) == 0) ? $urandom_range(50, 63)
                                         : $urandom_range(0, 49);
        set_idx(i, x, y);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
